fpga_input_cond: RTL and testbench



---
 rtl/rvc_fpga_pkg.sv | 16 +
 rtl/fpga_input_cond_debounce_bit.sv | 62 ++++++
 rtl/fpga_input_cond.sv | 59 +++++
 tb/tb_fpga_input_cond.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rvc_fpga_pkg.sv
// Shared board-level constants for the FPGA wrapper around rvc_top_5pl.
// The debounce window defaults to 10 ms at the 50 MHz board clock.
package rvc_fpga_pkg;

  localparam int CLK_FREQ_HZ             = 50_000_000;
  localparam int DEBOUNCE_MS             = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int NUM_SW                  = 10;
  localparam int NUM_BTN                 = 2;

  // Counter width for a debounce window; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/fpga_input_cond_debounce_bit.sv
// One input bit: 2-FF synchronizer, optional inversion, then a counter that
// requires DEBOUNCE_CYCLES consecutive differing samples before accepting a level.
module debounce_bit
  import rvc_fpga_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RST_VAL         = 1'b0,
  parameter bit   INVERT          = 1'b0
) (
  input  logic Clock,
  input  logic Rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             st_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic             sample;

  // Inversion happens after synchronization so the counter always sees active-high.
  assign sample = INVERT ? ~s2_reg : s2_reg;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      s1_reg   <= RST_VAL;
      s2_reg   <= RST_VAL;
      cnt_reg  <= '0;
      st_reg   <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      s1_reg   <= raw;
      s2_reg   <= s1_reg;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (sample == st_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        st_reg   <= sample;
        cnt_reg  <= '0;
        rise_reg <= sample;
        fall_reg <= ~sample;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign level = st_reg;
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/fpga_input_cond.sv
// Conditions raw slide-switch and push-button pins into clean active-high
// levels plus one-cycle change/press/release pulses for the CR_MEM inputs.
module fpga_input_cond #(
  parameter int NUM_SW          = rvc_fpga_pkg::NUM_SW,
  parameter int NUM_BTN         = rvc_fpga_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = rvc_fpga_pkg::DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               Clock,
  input  logic               Rst,
  input  logic [NUM_SW-1:0]  SW_raw,
  input  logic [NUM_BTN-1:0] BUTTON_raw,
  output logic [NUM_SW-1:0]  Switch,
  output logic [NUM_BTN-1:0] Button,
  output logic [NUM_SW-1:0]  Switch_change,
  output logic [NUM_BTN-1:0] Button_press,
  output logic [NUM_BTN-1:0] Button_release
);

  logic [NUM_SW-1:0] sw_rise;
  logic [NUM_SW-1:0] sw_fall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (1'b0),
        .INVERT         (1'b0)
      ) u_db (
        .Clock(Clock),
        .Rst  (Rst),
        .raw  (SW_raw[gi]),
        .level(Switch[gi]),
        .rise (sw_rise[gi]),
        .fall (sw_fall[gi])
      );
    end

    // Buttons idle high on the board; the synchronizer resets to "released".
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RST_VAL        (1'b1),
        .INVERT         (1'b1)
      ) u_db (
        .Clock(Clock),
        .Rst  (Rst),
        .raw  (BUTTON_raw[gi]),
        .level(Button[gi]),
        .rise (Button_press[gi]),
        .fall (Button_release[gi])
      );
    end
  endgenerate

  // Rise and fall are registered and mutually exclusive, so the OR stays glitch-free.
  assign Switch_change = sw_rise | sw_fall;

endmodule

// File: tb/tb_fpga_input_cond.sv
// Scoreboard bench for fpga_input_cond with a 4-cycle debounce window:
// stimulus queues expected pulse events, a negedge monitor pops and compares them.
module tb_fpga_input_cond;

  localparam int NSW  = 10;
  localparam int NBTN = 2;
  localparam int DB   = 4;
  localparam int LAT  = DB + 2;  // drive at negedge N -> pulse observed at cycle N+LAT

  typedef struct {
    int             cyc;
    logic [NSW-1:0]  sw;
    logic [NBTN-1:0] btn;
    logic [NSW-1:0]  chg;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
  } event_t;

  logic            Clock;
  logic            Rst;
  logic [NSW-1:0]  SW_raw;
  logic [NBTN-1:0] BUTTON_raw;
  logic [NSW-1:0]  Switch;
  logic [NBTN-1:0] Button;
  logic [NSW-1:0]  Switch_change;
  logic [NBTN-1:0] Button_press;
  logic [NBTN-1:0] Button_release;

  int     cyc;
  int     total;
  int     bad;
  event_t exp_q[$];

  fpga_input_cond #(
    .NUM_SW         (NSW),
    .NUM_BTN        (NBTN),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .Clock         (Clock),
    .Rst           (Rst),
    .SW_raw        (SW_raw),
    .BUTTON_raw    (BUTTON_raw),
    .Switch        (Switch),
    .Button        (Button),
    .Switch_change (Switch_change),
    .Button_press  (Button_press),
    .Button_release(Button_release)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input int at, input logic [NSW-1:0] sw, input logic [NBTN-1:0] btn,
                      input logic [NSW-1:0] chg, input logic [NBTN-1:0] press,
                      input logic [NBTN-1:0] rel);
    event_t e;
    e.cyc = at; e.sw = sw; e.btn = btn; e.chg = chg; e.press = press; e.rel = rel;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Monitor: every pulse the DUT presents must match the next queued event.
  always @(negedge Clock) begin
    if ((Switch_change != '0) || (Button_press != '0) || (Button_release != '0)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: chg=0x%0h press=0x%0h rel=0x%0h expected none (cycle %0d)",
                 Switch_change, Button_press, Button_release, cyc);
      end else begin
        event_t e;
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_outputs", int'({Switch, Button, Switch_change, Button_press, Button_release}),
              int'({e.sw, e.btn, e.chg, e.press, e.rel}));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 20000");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    Rst        = 1'b1;
    SW_raw     = '0;
    BUTTON_raw = 2'b11;
    #1;
    check("reset_outputs", int'({Switch, Button, Switch_change, Button_press, Button_release}), 0);
    wait_cyc(3);
    Rst = 1'b0;
    wait_cyc(8);
    check("idle_levels", int'({Switch, Button}), 0);

    // Clean press and release of button 0
    BUTTON_raw = 2'b10;
    push(cyc + LAT, 10'h000, 2'b01, 10'h000, 2'b01, 2'b00);
    wait_cyc(10);
    check("press_held_level", int'(Button), 1);
    BUTTON_raw = 2'b11;
    push(cyc + LAT, 10'h000, 2'b00, 10'h000, 2'b00, 2'b01);
    wait_cyc(10);

    // Bounce on switch 3: 3 high, 1 low, 3 high, low -> rejected
    SW_raw[3] = 1'b1; wait_cyc(3);
    SW_raw[3] = 1'b0; wait_cyc(1);
    SW_raw[3] = 1'b1; wait_cyc(3);
    SW_raw[3] = 1'b0; wait_cyc(8);
    check("bounce_rejected", int'(Switch), 0);

    // 6 high cycles are accepted, then the return to low is accepted too
    SW_raw[3] = 1'b1;
    push(cyc + LAT, 10'h008, 2'b00, 10'h008, 2'b00, 2'b00);
    wait_cyc(6);
    SW_raw[3] = 1'b0;
    push(cyc + LAT, 10'h000, 2'b00, 10'h008, 2'b00, 2'b00);
    wait_cyc(10);

    // Simultaneous switch and button changes
    SW_raw     = 10'h155;
    BUTTON_raw = 2'b00;
    push(cyc + LAT, 10'h155, 2'b11, 10'h155, 2'b11, 2'b00);
    wait_cyc(10);
    check("simul_levels", int'({Switch, Button}), int'({10'h155, 2'b11}));

    // Asynchronous reset mid-simulation: outputs clear without a clock edge
    #2;
    SW_raw = 10'h3FF;
    Rst    = 1'b1;
    #1;
    check("async_reset_clear", int'({Switch, Button, Switch_change, Button_press, Button_release}), 0);
    @(negedge Clock);
    Rst = 1'b0;
    push(cyc + LAT, 10'h3FF, 2'b11, 10'h3FF, 2'b11, 2'b00);
    wait_cyc(10);

    // Back to idle
    SW_raw     = 10'h000;
    BUTTON_raw = 2'b11;
    push(cyc + LAT, 10'h000, 2'b00, 10'h3FF, 2'b00, 2'b11);
    wait_cyc(10);

    // Reset mid-count discards progress; switch 0 must re-qualify from zero
    begin
      int n;
      n = cyc;
      SW_raw[0] = 1'b1;
      wait_cyc(2);
      Rst = 1'b1;
      wait_cyc(1);
      Rst = 1'b0;
      push(n + 3 + LAT, 10'h001, 2'b00, 10'h001, 2'b00, 2'b00);
      wait_cyc(4);
      check("midcount_not_early", int'(Switch), 0);
      wait_cyc(8);
      check("midcount_level", int'(Switch), 1);
    end

    wait_cyc(4);
    check("events_all_seen", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
